fifo_wr_arb: RTL and testbench

Round-robin write arbiter that shares the single write port of one `fifo` instance among N requesters. Each requester presents a word with a request and receives a same-cycle acknowledge when the word is written. The block sits directly in front of `fifo.data_i`/`fifo.wr`/`fifo.full_o`. Arbitration state is registered; the grant path is combinational, so there is zero added latency.

---
 rtl/fifo_wr_arb.sv | 185 ++++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin arbiter sharing one fifo write port among N requesters
// Optional burst locking is enabled by defining FIFO_ARB_BURST_EN.
module fifo_wr_arb #(
  parameter int N      = 4,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_i,
  input  logic [N*DWIDTH-1:0]  data_i,
  output logic [N-1:0]         ack_o,
  output logic                 wr_o,
  output logic [DWIDTH-1:0]    wdata_o,
  input  logic                 full_i,
  output logic [$clog2(N)-1:0] owner_o
);

  localparam int            PW   = $clog2(N);
  localparam logic [PW-1:0] LAST = PW'(N - 1);

  // Reject parameter values the arbiter is not built for.
  generate
    if (N < 2 || N > 16 || BURST < 1) begin : g_bad_param
      $error("fifo_wr_arb: N must be 2..16 and BURST must be >= 1");
    end
  endgenerate

  // Wrap-around increment of a requester index.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] k);
    return (k == LAST) ? '0 : k + PW'(1);
  endfunction

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic          win_found;
  logic [PW-1:0] win_idx;
  logic          grant_ok;   // some requester is eligible this cycle
  logic [PW-1:0] grant_idx;  // which one
  logic          xfer;       // a word moves on the next edge

  // Find the first active request starting at the priority pointer.
  always_comb begin : p_search
    int            cand;
    logic [PW-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = PW'(cand);
      if (!win_found && req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

`ifdef FIFO_ARB_BURST_EN
  localparam int            BW      = $clog2(BURST + 1);
  localparam logic [BW-1:0] BURST_B = BW'(BURST);
  localparam logic [0:0]    ST_ARB  = 1'b0;
  localparam logic [0:0]    ST_LOCK = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] lock_q, lock_d;
  logic [BW-1:0] beats_q, beats_d;

  // While locked only the burst owner is eligible; otherwise plain round robin.
  always_comb begin
    grant_ok  = win_found;
    grant_idx = win_idx;
    if (state_q == ST_LOCK) begin
      grant_ok  = req_i[lock_q];
      grant_idx = lock_q;
    end
  end
`else
  // Per-word round robin: the search winner is the grant.
  always_comb begin
    grant_ok  = win_found;
    grant_idx = win_idx;
  end
`endif

  assign xfer = grant_ok && !full_i && !rst;

  // One-hot acknowledge and write-data steering for the granted requester.
  always_comb begin
    ack_o   = '0;
    wdata_o = '0;
    if (xfer) begin
      ack_o[grant_idx] = 1'b1;
    end
    for (int k = 0; k < N; k++) begin
      if (ack_o[k]) begin
        wdata_o = wdata_o | data_i[k*DWIDTH +: DWIDTH];
      end
    end
  end

  assign wr_o    = |ack_o;
  assign owner_o = owner_q;

`ifdef FIFO_ARB_BURST_EN
  // Next-state logic: burst lock entry, beat counting and lock release.
  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    state_d = state_q;
    lock_d  = lock_q;
    beats_d = beats_q;
    if (xfer) begin
      owner_d = grant_idx;
    end
    if (state_q == ST_LOCK) begin
      if (!req_i[lock_q]) begin
        // Owner walked away: release without a transfer this cycle.
        state_d = ST_ARB;
        beats_d = '0;
        ptr_d   = next_idx(lock_q);
      end else if (xfer) begin
        if (beats_q + BW'(1) == BURST_B) begin
          state_d = ST_ARB;
          beats_d = '0;
          ptr_d   = next_idx(lock_q);
        end else begin
          beats_d = beats_q + BW'(1);
        end
      end
    end else if (xfer) begin
      if (BURST > 1) begin
        state_d = ST_LOCK;
        lock_d  = grant_idx;
        beats_d = BW'(1);
      end else begin
        ptr_d = next_idx(grant_idx);
      end
    end
  end

  // Arbitration and burst state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
      state_q <= ST_ARB;
      lock_q  <= '0;
      beats_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      state_q <= state_d;
      lock_q  <= lock_d;
      beats_q <= beats_d;
    end
  end
`else
  // Next-state logic: pointer moves past the requester that just transferred.
  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (xfer) begin
      owner_d = grant_idx;
      ptr_d   = next_idx(grant_idx);
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb
module tb_fifo_wr_arb;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int BURST = 4;

  logic            clk  = 1'b0;
  logic            rst  = 1'b1;
  logic [N-1:0]    req  = '0;
  logic [N*DW-1:0] data = '0;
  logic            full = 1'b0;
  logic [N-1:0]    ack;
  logic            wr;
  logic [DW-1:0]   wdata;
  logic [1:0]      owner;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.N(N), .DWIDTH(DW), .BURST(BURST)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_i   (req),
    .data_i  (data),
    .ack_o   (ack),
    .wr_o    (wr),
    .wdata_o (wdata),
    .full_i  (full),
    .owner_o (owner)
  );

  // Reference state: pointer, last owner, burst lock.
  int    m_ptr   = 0;
  int    m_owner = 0;
  int    m_lock  = 0;
  int    m_lk    = 0;
  int    m_beats = 0;
  bit    started = 0;
  string ack_log  = "";
  string data_log = "";

  function automatic int model_winner();
    if (rst || full) return -1;
`ifdef FIFO_ARB_BURST_EN
    if (m_lock != 0) return req[m_lk] ? m_lk : -1;
`endif
    for (int i = 0; i < N; i++) begin
      if (req[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%s expected=%s", name, act, exp);
    end
  endtask

  // Advance the model on each edge and record who transferred.
  always @(posedge clk) begin
    int w;
    w = model_winner();
    if (w >= 0) begin
      ack_log  = {ack_log, $sformatf("%0d", w)};
      data_log = {data_log, $sformatf("%02h", data[w*DW +: DW])};
    end
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_lock = 0; m_lk = 0; m_beats = 0;
    end else begin
`ifdef FIFO_ARB_BURST_EN
      if (m_lock != 0) begin
        if (!req[m_lk]) begin
          m_lock = 0; m_beats = 0; m_ptr = (m_lk + 1) % N;
        end else if (w >= 0) begin
          m_owner = w;
          m_beats++;
          if (m_beats == BURST) begin
            m_lock = 0; m_beats = 0; m_ptr = (m_lk + 1) % N;
          end
        end
      end else if (w >= 0) begin
        m_owner = w;
        if (BURST > 1) begin
          m_lock = 1; m_lk = w; m_beats = 1;
        end else begin
          m_ptr = (w + 1) % N;
        end
      end
`else
      if (w >= 0) begin
        m_owner = w;
        m_ptr   = (w + 1) % N;
      end
`endif
    end
    started = 1;
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    int            w;
    logic [N-1:0]  ea;
    logic [DW-1:0] ed;
    if (started) begin
      w  = model_winner();
      ea = '0;
      ed = '0;
      if (w >= 0) begin
        ea[w] = 1'b1;
        ed    = data[w*DW +: DW];
      end
      chk("ack_o", 32'(ack), 32'(ea));
      chk("wr_o", 32'(wr), 32'(ea != '0));
      chk("wdata_o", 32'(wdata), 32'(ed));
      chk("owner_o", 32'(owner), 32'(m_owner));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    full = 1'b0;
    step(1);
    rst      = 1'b0;
    ack_log  = "";
    data_log = "";
  endtask

  initial begin
    step(2);
    data = {8'h3c, 8'h2b, 8'h1a, 8'h09};

    // Single requester streaming three words.
    do_reset();
    req = 4'b0010;
    data[15:8] = 8'hA0;
    @(negedge clk);
    chk("t1_first_ack", 32'(ack), 32'h2);
    step(1);
    data[15:8] = 8'hA1;
    step(1);
    data[15:8] = 8'hA2;
    step(1);
    req = '0;
    step(1);
    chk_str("t1_order", ack_log, "111");
    chk_str("t1_data", data_log, "a0a1a2");
    chk("t1_owner", 32'(owner), 32'd1);

`ifndef FIFO_ARB_BURST_EN
    // All four requesting continuously.
    do_reset();
    req = 4'b1111;
    step(6);
    req = '0;
    step(1);
    chk_str("t2_all4", ack_log, "012301");

    // Only 0 and 2 requesting.
    do_reset();
    req = 4'b0101;
    step(4);
    req = '0;
    step(1);
    chk_str("t2_pair", ack_log, "0202");

    // Full stall after a grant to requester 1.
    do_reset();
    req = 4'b0010;
    step(1);
    req  = 4'b1111;
    full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_wr_full", 32'(wr), 32'd0);
      step(1);
    end
    full = 1'b0;
    step(1);
    req = '0;
    step(1);
    chk_str("t3_resume", ack_log, "12");

    // Reset in mid-operation.
    do_reset();
    req = 4'b1111;
    step(2);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_ack_rst", 32'(ack), 32'd0);
    chk("t4_wr_rst", 32'(wr), 32'd0);
    chk("t4_wdata_rst", 32'(wdata), 32'd0);
    step(1);
    chk("t4_owner_rst", 32'(owner), 32'd0);
    rst = 1'b0;
    step(1);
    req = '0;
    step(1);
    chk_str("t4_order", ack_log, "010");
`else
    // Bursts of four between requesters 0 and 2.
    do_reset();
    req = 4'b0101;
    step(12);
    req = '0;
    step(1);
    chk_str("b1_bursts", ack_log, "000022220000");

    // Full stall in the middle of a burst.
    do_reset();
    req = 4'b0101;
    step(2);
    full = 1'b1;
    step(3);
    full = 1'b0;
    step(3);
    req = '0;
    step(1);
    chk_str("b2_stall", ack_log, "00002");

    // Lock owner drops its request.
    do_reset();
    req = 4'b1100;
    step(2);
    req = 4'b1000;
    @(negedge clk);
    chk("b3_idle", 32'(ack), 32'd0);
    step(2);
    req = '0;
    step(1);
    chk_str("b3_order", ack_log, "223");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
